activation_result_serializer: RTL and testbench
===============================================

Name: activation_result_serializer

Overview:
Sink-side partner of the 30-channel parallel activation layer. It captures each completed activation vector (DATA_W x NUM_CH) when the layer's ready_activation pulses high, and buffers up to DEPTH vectors. It streams the buffered vectors out one channel per cycle over a valid/ready interface to the next layer (pooling/dense feeder). The upstream layer has no backpressure, so lost vectors are flagged rather than stalled.

Parameters:
NUM_CH, 30, channels per vector (output index 1..NUM_CH)
DATA_W, 16, signed feature width
DEPTH, 2, vector buffer depth (power of 2, >=2)

Ports:
clk  input  1  clock, rising edge
n_reset  input  1  synchronous active-low reset
in_feature  input  DATA_W x [NUM_CH:1] signed  activated vector from activation layer
in_valid  input  1  ready_activation from activation layer (level)
in_space  output  1  buffer has a free slot (count<DEPTH)
out_data  output  DATA_W signed  current channel value
out_ch  output  5  current channel index, 1..NUM_CH
out_valid  output  1  out_data/out_ch valid
out_ready  input  1  downstream accepts
out_last  output  1  out_ch==NUM_CH while out_valid
overflow  output  1  sticky: vector dropped
busy  output  1  count!=0
neg_err  output  1  sticky negative-value flag (see Optional Feature)

Behaviour:
- Reset: sync only; when n_reset=0 at clk edge: count=0, wr/rd ptrs=0, state=IDLE, out_ch=1, in_valid_d=0, overflow=0, neg_err=0. Outputs after reset: out_valid=0, out_last=0, out_data=0, busy=0, in_space=1. Reset mid-stream discards all buffered data; no partial vector completes.
- Capture: push = in_valid & ~in_valid_d (rising edge; in_valid_d registered). A level held high captures once. Because in_valid_d resets to 0, in_valid high on the first cycle out of reset counts as one edge. in_feature is sampled on the push cycle into buf[wr_ptr]; wr_ptr wraps modulo DEPTH.
- Full: push when count==DEPTH and no pop this cycle -> vector dropped, overflow<=1, pointers/count unchanged. Push with count==DEPTH and a same-cycle pop -> accepted (slot freed same edge).
- Pop: when out_valid & out_ready & out_last. rd_ptr advances modulo DEPTH. count' = count + push_accepted - pop.
- FSM IDLE: out_valid=0. Go to STREAM when count!=0 (registered; first beat appears the cycle after count becomes nonzero, i.e. capture-to-first-beat latency 2 cycles).
- FSM STREAM: out_valid=1, out_data=buf[rd_ptr][out_ch]. On beat (valid&ready) with out_ch<NUM_CH: out_ch++. On last beat: out_ch<=1, pop. Stay in STREAM if count after update !=0 (back-to-back vectors, no bubble), else IDLE.
- Without out_ready, out_data/out_ch hold stable. A vector is exactly NUM_CH beats.
- in_space is combinational from the registered count.

Optional Feature:
Macro ACT_SER_NEG_CHECK_EN. When defined: any beat whose buffered value is negative is output as 0, and neg_err<=1 (sticky until reset). When undefined: values pass unchanged and neg_err is tied to 0.

Test Plan:
- Single vector ch[k]=k*3: in_valid high 1 cycle, out_ready=1 -> out_valid starts 2 cycles later, 30 beats out_data 3..90, out_last only on out_ch=30, then busy=0.
- in_valid held high 5 cycles -> exactly one vector (30 beats) emitted, overflow=0.
- Three edges 4 cycles apart, out_ready=0 -> first two stored, third dropped, overflow=1. Releasing out_ready -> 60 beats, back-to-back with no idle cycle between vectors.
- out_ready toggling 1/0 each cycle -> out_data/out_ch stable while stalled, all 30 values in order, 60 cycles total.
- Count=DEPTH with an edge on the pop cycle of the last beat -> vector accepted, overflow stays 0.
- Reset asserted at beat 12 -> next cycle out_valid=0, busy=0, overflow=0, out_ch=1. With ACT_SER_NEG_CHECK_EN, ch5=-7 -> out_data=0 and neg_err=1.

Source files
------------

// File: rtl/activation_result_serializer.sv
// Buffers activation vectors and streams them one channel per beat.
// Optional macro ACT_SER_NEG_CHECK_EN zeroes negative beats, sets neg_err.
//
// Ports:
//   clk, n_reset          clock, synchronous active-low reset
//   in_feature, in_valid  vector from activation layer, capture on rise
//   in_space              buffer has a free slot
//   out_data, out_ch      current channel value and index (1..NUM_CH)
//   out_valid, out_ready  downstream handshake
//   out_last              last channel of a vector is on the bus
//   overflow              sticky: a vector arrived while full and was lost
//   busy                  at least one vector buffered
//   neg_err               sticky: a negative value was zeroed (macro only)
module activation_result_serializer #(
  parameter int NUM_CH = 30,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                           clk,
  input  logic                           n_reset,
  input  logic [NUM_CH:1][DATA_W-1:0]    in_feature,
  input  logic                           in_valid,
  output logic                           in_space,
  output logic signed [DATA_W-1:0]       out_data,
  output logic [4:0]                     out_ch,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic                           out_last,
  output logic                           overflow,
  output logic                           busy,
  output logic                           neg_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] ZERO_C  = '0;
  localparam logic [4:0]    LAST_CH = 5'(NUM_CH);
  localparam logic [4:0]    FIRST_CH = 5'd1;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t state;

  logic [NUM_CH:1][DATA_W-1:0] vec_q [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic          in_valid_d;

  logic push;
  logic fire;
  logic pop;
  logic full;
  logic accept;
  logic drop;

  logic [DATA_W-1:0] raw;
  logic              raw_neg;

  // Upstream holds ready_activation as a level; only the rise is a vector.
  assign push   = in_valid & ~in_valid_d;
  assign fire   = out_valid & out_ready;
  assign pop    = fire & out_last;
  assign full   = (count == DEPTH_C);

  // A pop on the same edge frees the slot, so a full buffer still accepts.
  assign accept = push & (~full | pop);
  assign drop   = push & full & ~pop;

  assign count_nx = count + CW'(accept) - CW'(pop);

  assign in_space  = (count < DEPTH_C);
  assign busy      = (count != ZERO_C);
  assign out_valid = (state == STREAM);
  assign out_last  = out_valid & (out_ch == LAST_CH);

  assign raw     = vec_q[rd_ptr][out_ch];
  assign raw_neg = raw[DATA_W-1];

`ifdef ACT_SER_NEG_CHECK_EN
  always_comb begin
    out_data = '0;
    if (out_valid && !raw_neg) begin
      out_data = raw;
    end
  end
`else
  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data = raw;
    end
  end
`endif

  // Vector storage carries no reset; the pointers make stale slots invisible.
  always_ff @(posedge clk) begin
    if (accept) begin
      vec_q[wr_ptr] <= in_feature;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      in_valid_d <= 1'b0;
      out_ch     <= FIRST_CH;
      overflow   <= 1'b0;
    end else begin
      in_valid_d <= in_valid;
      count      <= count_nx;

      if (drop) begin
        overflow <= 1'b1;
      end
      if (accept) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      unique case (state)
        IDLE: begin
          if (count != ZERO_C) begin
            state <= STREAM;
          end
        end
        STREAM: begin
          if (fire) begin
            if (out_last) begin
              out_ch <= FIRST_CH;
              // Back-to-back vectors continue without a bubble.
              if (count_nx == ZERO_C) begin
                state <= IDLE;
              end
            end else begin
              out_ch <= out_ch + 5'd1;
            end
          end
        end
      endcase
    end
  end

`ifdef ACT_SER_NEG_CHECK_EN
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      neg_err <= 1'b0;
    end else if (fire && raw_neg) begin
      neg_err <= 1'b1;
    end
  end
`else
  assign neg_err = 1'b0;
  logic unused_neg;
  assign unused_neg = raw_neg;
`endif

endmodule

// File: tb/tb_activation_result_serializer.sv
// Directed self-checking bench for activation_result_serializer.
// One task per scenario, each doing its own inline comparisons.
module tb_activation_result_serializer;

  localparam int N = 30;

  typedef logic [N:1][15:0] vec_t;

  logic               clk = 1'b0;
  logic               n_reset;
  vec_t               in_feature;
  logic               in_valid;
  logic               in_space;
  logic signed [15:0] out_data;
  logic [4:0]         out_ch;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               overflow;
  logic               busy;
  logic               neg_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  activation_result_serializer #(
    .NUM_CH(N),
    .DATA_W(16),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .n_reset(n_reset),
    .in_feature(in_feature),
    .in_valid(in_valid),
    .in_space(in_space),
    .out_data(out_data),
    .out_ch(out_ch),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last(out_last),
    .overflow(overflow),
    .busy(busy),
    .neg_err(neg_err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  function automatic vec_t mk(input int base, input int step);
    vec_t v;
    for (int k = 1; k <= N; k++) v[k] = 16'(base + step * k);
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input vec_t v);
    in_feature = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset;
    n_reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    n_reset = 1'b1;
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    ok = out_valid;
  endtask

  task automatic test_reset;
    in_feature = mk(0, 0);
    do_reset();
    total++;
    if ({out_valid, out_last, busy, in_space, overflow, neg_err}
        !== 6'b000100) begin
      bad++;
      $display("FAIL reset_flags: got v%b l%b b%b s%b o%b n%b want 000100",
               out_valid, out_last, busy, in_space, overflow, neg_err);
    end
    total++;
    if (out_ch !== 5'd1 || out_data !== 16'sd0) begin
      bad++;
      $display("FAIL reset_out: got ch=%0d data=%0d want ch=1 data=0",
               out_ch, out_data);
    end
  endtask

  task automatic test_single;
    do_reset();
    out_ready = 1'b1;
    in_feature = mk(0, 3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b1 || in_space !== 1'b1) begin
      bad++;
      $display("FAIL single_lat1: got v=%b busy=%b space=%b want 0 1 1",
               out_valid, busy, in_space);
    end
    tick();
    for (int k = 1; k <= N; k++) begin
      total++;
      if ({out_valid, out_ch, out_data, out_last} !==
          {1'b1, 5'(k), 16'(3 * k), (k == N)}) begin
        bad++;
        $display("FAIL single_beat%0d: got v=%b ch=%0d d=%0d l=%b want 1 %0d %0d %b",
                 k, out_valid, out_ch, out_data, out_last, k, 3 * k, k == N);
      end
      tick();
    end
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_end: got busy=%b v=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_hold;
    int beats;
    do_reset();
    out_ready = 1'b1;
    in_feature = mk(100, 1);
    in_valid = 1'b1;
    beats = 0;
    for (int i = 0; i < 80; i++) begin
      if (i == 5) in_valid = 1'b0;
      if (out_valid && out_ready) begin
        beats++;
        total++;
        if (out_ch !== 5'(beats) || out_data !== 16'(100 + beats)) begin
          bad++;
          $display("FAIL hold_beat%0d: got ch=%0d d=%0d want %0d %0d",
                   beats, out_ch, out_data, beats, 100 + beats);
        end
      end
      tick();
    end
    total++;
    if (beats != N || overflow !== 1'b0) begin
      bad++;
      $display("FAIL hold_count: got beats=%0d ovf=%b want 30 0",
               beats, overflow);
    end
  endtask

  task automatic test_overflow;
    int v;
    int c;
    do_reset();
    pulse(mk(1000, 1));
    tick();
    tick();
    pulse(mk(2000, 1));
    tick();
    tick();
    pulse(mk(3000, 1));
    tick();
    tick();
    total++;
    if ({overflow, in_space, busy, out_valid} !== 4'b1011 ||
        out_ch !== 5'd1) begin
      bad++;
      $display("FAIL ovf_flags: got o%b s%b b%b v%b ch=%0d want 1011 ch=1",
               overflow, in_space, busy, out_valid, out_ch);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 2 * N; i++) begin
      v = i / N;
      c = (i % N) + 1;
      total++;
      if ({out_valid, out_ch, out_data} !==
          {1'b1, 5'(c), 16'(1000 * (v + 1) + c)}) begin
        bad++;
        $display("FAIL ovf_beat%0d: got v=%b ch=%0d d=%0d want 1 %0d %0d",
                 i, out_valid, out_ch, out_data, c, 1000 * (v + 1) + c);
      end
      tick();
    end
    total++;
    if ({out_valid, busy, overflow} !== 3'b001) begin
      bad++;
      $display("FAIL ovf_end: got v=%b busy=%b ovf=%b want 0 0 1",
               out_valid, busy, overflow);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_toggle;
    bit ok;
    int expch;
    do_reset();
    pulse(mk(50, 2));
    wait_valid(ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL toggle_start: got out_valid=0 want 1 within 50 cycles");
    end
    expch = 1;
    for (int i = 0; i < 2 * N - 1; i++) begin
      total++;
      if ({out_valid, out_ch, out_data} !==
          {1'b1, 5'(expch), 16'(50 + 2 * expch)}) begin
        bad++;
        $display("FAIL toggle_cyc%0d: got v=%b ch=%0d d=%0d want 1 %0d %0d",
                 i, out_valid, out_ch, out_data, expch, 50 + 2 * expch);
      end
      out_ready = (i % 2 == 0);
      tick();
      if (out_ready) expch++;
    end
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL toggle_end: got v=%b busy=%b want 0 0", out_valid, busy);
    end
  endtask

  task automatic test_full_pop;
    int v;
    int c;
    do_reset();
    pulse(mk(1000, 1));
    pulse(mk(2000, 1));
    total++;
    if (in_space !== 1'b0 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL fullpop_full: got space=%b ovf=%b want 0 0",
               in_space, overflow);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3 * N; i++) begin
      v = i / N;
      c = (i % N) + 1;
      total++;
      if ({out_valid, out_ch, out_data} !==
          {1'b1, 5'(c), 16'(1000 * (v + 1) + c)}) begin
        bad++;
        $display("FAIL fullpop_beat%0d: got v=%b ch=%0d d=%0d want 1 %0d %0d",
                 i, out_valid, out_ch, out_data, c, 1000 * (v + 1) + c);
      end
      if (i == N - 1) begin
        in_feature = mk(3000, 1);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
    end
    in_valid = 1'b0;
    total++;
    if ({overflow, busy, out_valid} !== 3'b000) begin
      bad++;
      $display("FAIL fullpop_end: got ovf=%b busy=%b v=%b want 000",
               overflow, busy, out_valid);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    int n;
    do_reset();
    pulse(mk(10, 1));
    pulse(mk(20, 1));
    pulse(mk(30, 1));
    total++;
    if (overflow !== 1'b1) begin
      bad++;
      $display("FAIL midrst_ovf: got ovf=%b want 1", overflow);
    end
    out_ready = 1'b1;
    n = 0;
    while (out_ch != 5'd12 && n < 40) begin
      tick();
      n++;
    end
    total++;
    if (out_ch !== 5'd12 || out_data !== 16'sd22) begin
      bad++;
      $display("FAIL midrst_reach: got ch=%0d d=%0d want 12 22",
               out_ch, out_data);
    end
    n_reset = 1'b0;
    tick();
    total++;
    if ({out_valid, busy, overflow, in_space} !== 4'b0001 ||
        out_ch !== 5'd1) begin
      bad++;
      $display("FAIL midrst_clear: got v%b b%b o%b s%b ch=%0d want 0001 ch=1",
               out_valid, busy, overflow, in_space, out_ch);
    end
    n_reset = 1'b1;
    repeat (5) tick();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL midrst_quiet: got v=%b busy=%b want 0 0",
               out_valid, busy);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_neg;
    vec_t v;
    logic signed [15:0] exp5;
    logic exp_err;
`ifdef ACT_SER_NEG_CHECK_EN
    exp5 = 16'sd0;
    exp_err = 1'b1;
`else
    exp5 = -16'sd7;
    exp_err = 1'b0;
`endif
    do_reset();
    v = mk(0, 1);
    v[5] = 16'hFFF9;
    out_ready = 1'b1;
    pulse(v);
    for (int k = 1; k <= N; k++) begin
      if (k == 5) begin
        total++;
        if (out_ch !== 5'd5 || out_data !== exp5) begin
          bad++;
          $display("FAIL neg_ch5: got ch=%0d d=%0d want 5 %0d",
                   out_ch, out_data, exp5);
        end
      end
      if (k == 6) begin
        total++;
        if (out_ch !== 5'd6 || out_data !== 16'sd6) begin
          bad++;
          $display("FAIL neg_ch6: got ch=%0d d=%0d want 6 6",
                   out_ch, out_data);
        end
      end
      tick();
    end
    total++;
    if (neg_err !== exp_err || busy !== 1'b0) begin
      bad++;
      $display("FAIL neg_flag: got neg_err=%b busy=%b want %b 0",
               neg_err, busy, exp_err);
    end
    out_ready = 1'b0;
  endtask

  initial begin
    n_reset = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_feature = '0;
    test_reset();
    test_single();
    test_hold();
    test_overflow();
    test_toggle();
    test_full_pop();
    test_reset_mid();
    test_neg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
